// File: rtl/fclass_sched.sv
// Round-robin arbiter in front of a shared single-precision classify datapath.
// The granted operand's class mask and owner id are held in a one-entry result register.
module fclass_sched #(
   parameter int NREQ     = 4,
   parameter int IDW      = $clog2(NREQ),
   parameter int XLEN     = 32,
   parameter int EXPWIDTH = 8,
   parameter int SIGWIDTH = 24
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NREQ-1:0]                 req_valid,
   input  logic [NREQ*(EXPWIDTH+SIGWIDTH)-1:0] req_data,
   output logic [NREQ-1:0]                 req_ready,
   output logic                            resp_valid,
   input  logic                            resp_ready,
   output logic [IDW-1:0]                  resp_id,
   output logic [XLEN-1:0]                 resp_class,
   output logic [15:0]                     issue_cnt
);

   localparam int OPW = EXPWIDTH + SIGWIDTH;
   localparam int FW  = SIGWIDTH - 1;

   typedef enum logic {EMPTY, FULL} state_t;

   state_t            state_reg, state_next;
   logic [IDW-1:0]    rr_ptr_reg, rr_ptr_next;
   logic [IDW-1:0]    id_reg, id_next;
   logic [XLEN-1:0]   class_reg, class_next;
   logic [15:0]       cnt_reg, cnt_next;

   logic [OPW-1:0]    operand [NREQ];
   logic [IDW:0]      pick_res;
   logic              grant_found;
   logic [IDW-1:0]    grant_idx;
   logic [NREQ-1:0]   grant;
   logic              can_accept;
   logic              accept;
   logic [9:0]        sel_class;

   for (genvar gi = 0; gi < NREQ; gi++) begin : g_split
      assign operand[gi] = req_data[gi*OPW +: OPW];
   end

   // First valid requester at or after ptr, wrapping around.
   function automatic logic [IDW:0] pick(input logic [NREQ-1:0] v, input logic [IDW-1:0] ptr);
      logic           found;
      logic [IDW-1:0] idx;
      logic [IDW-1:0] cand;
      int             pos;
      found = 1'b0;
      idx   = '0;
      for (int k = 0; k < NREQ; k++) begin
         pos = int'(ptr) + k;
         if (pos >= NREQ) pos = pos - NREQ;
         cand = IDW'(pos);
         if (!found && v[cand]) begin
            found = 1'b1;
            idx   = cand;
         end
      end
      return {found, idx};
   endfunction

   function automatic logic [9:0] classify(input logic [OPW-1:0] x);
      logic                sign;
      logic [EXPWIDTH-1:0] expo;
      logic [FW-1:0]       frac;
      logic                exp_max, exp_zero, frac_zero;
      logic [9:0]          m;
      sign      = x[OPW-1];
      expo      = x[OPW-2 -: EXPWIDTH];
      frac      = x[FW-1:0];
      exp_max   = &expo;
      exp_zero  = ~|expo;
      frac_zero = ~|frac;
      m = '0;
      if (exp_max && !frac_zero) begin
         if (frac[FW-1]) m[0] = 1'b1;
         else            m[1] = 1'b1;
      end else if (exp_max) begin
         if (sign) m[9] = 1'b1;
         else      m[2] = 1'b1;
      end else if (exp_zero && frac_zero) begin
         if (sign) m[6] = 1'b1;
         else      m[5] = 1'b1;
      end else if (exp_zero) begin
         if (sign) m[7] = 1'b1;
         else      m[4] = 1'b1;
      end else begin
         if (sign) m[8] = 1'b1;
         else      m[3] = 1'b1;
      end
      return m;
   endfunction

   assign pick_res    = pick(req_valid, rr_ptr_reg);
   assign grant_found = pick_res[IDW];
   assign grant_idx   = pick_res[IDW-1:0];
   assign grant       = grant_found ? (NREQ'(1) << grant_idx) : '0;
   assign can_accept  = (state_reg == EMPTY) || resp_ready;
   assign accept      = grant_found && can_accept;
   // rst gates ready so nothing looks accepted while the flops are held clear.
   assign req_ready   = rst ? '0 : (grant & {NREQ{can_accept}});
   assign sel_class   = classify(operand[grant_idx]);

   always_comb begin
      state_next  = state_reg;
      rr_ptr_next = rr_ptr_reg;
      id_next     = id_reg;
      class_next  = class_reg;
      cnt_next    = cnt_reg;
      if (accept) begin
         state_next  = FULL;
         rr_ptr_next = (grant_idx == IDW'(NREQ-1)) ? '0 : grant_idx + 1'b1;
         id_next     = grant_idx;
         class_next  = {{(XLEN-10){1'b0}}, sel_class};
         cnt_next    = cnt_reg + 16'd1;
      end else if (state_reg == FULL && resp_ready) begin
         state_next = EMPTY;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg  <= EMPTY;
         rr_ptr_reg <= '0;
         id_reg     <= '0;
         class_reg  <= '0;
         cnt_reg    <= '0;
      end else begin
         state_reg  <= state_next;
         rr_ptr_reg <= rr_ptr_next;
         id_reg     <= id_next;
         class_reg  <= class_next;
         cnt_reg    <= cnt_next;
      end
   end

   assign resp_valid = (state_reg == FULL);
   assign resp_id    = id_reg;
   assign resp_class = class_reg;
   assign issue_cnt  = cnt_reg;

endmodule

// File: doc/fclass_sched.md
# fclass_sched

Round-robin scheduler that shares one single-precision classification datapath between `NREQ` requesters. It arbitrates valid/ready requests, classifies the granted operand, and holds the result in a one-entry output register tagged with the requester index. It sits between the issue ports of the FPU and the classify datapath, alongside the other `utils/` blocks.

## Interface

- `NREQ`, 4: number of requesters, 2..8.
- `IDW`, 2: requester-id width, equal to clog2(`NREQ`).
- `XLEN`, `EXPWIDTH`, `SIGWIDTH`: taken from `params.vh`. The operand is `EXPWIDTH+SIGWIDTH` = 32 bits.

Ports:

- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous reset, active-high.
- `req_valid` in `NREQ`: bit i means requester i presents an operand.
- `req_data` in `NREQ*32`: operand of requester i at bits [32i+31:32i].
- `req_ready` out `NREQ`: one-hot or zero; the request is accepted when `req_valid[i] & req_ready[i]`.
- `resp_valid` out 1: result register holds a valid result.
- `resp_ready` in 1: consumer accepts the result this cycle.
- `resp_id` out `IDW`: index of the requester that owns the result.
- `resp_class` out `XLEN`: class mask, one-hot in [9:0], upper bits zero.
- `issue_cnt` out 16: count of accepted requests, wraps modulo 2^16.

## Operation

- **Class mask.** The mask is computed from sign s = bit 31, exponent e = [30:23] and fraction f = [22:0]:
  - bit9: neg inf (s=1, e=FF, f=0)
  - bit8: neg normal (s=1, e≠0, e≠FF)
  - bit7: neg subnormal (s=1, e=0, f≠0)
  - bit6: neg zero
  - bit5: pos zero
  - bit4: pos subnormal
  - bit3: pos normal
  - bit2: pos inf
  - bit1: sNaN (e=FF, f≠0, f[22]=0)
  - bit0: qNaN (e=FF, f[22]=1)
  - NaNs set only bit1 or bit0, regardless of sign.
  - Exactly one bit is set for every input.
- **Accept condition.** `can_accept = !resp_valid | resp_ready`.
- **Arbitration.**
  - Round-robin pointer `rr_ptr` (`IDW` bits).
  - The grant goes to the first i with `req_valid[i]` set, searching upward from `rr_ptr` with wrap-around.
  - `req_ready = grant & {NREQ{can_accept}}`.
  - `req_ready` is combinational from `req_valid`, `rr_ptr`, `resp_valid` and `resp_ready`. There is no combinational path from `req_data`.
- **On accept (any i):**
  - `resp_class` ← class(`req_data[i]`)
  - `resp_id` ← i
  - `resp_valid` ← 1
  - `rr_ptr` ← (i+1) mod `NREQ`
  - `issue_cnt` ← `issue_cnt` + 1
- **Without accept:**
  - If `resp_ready & resp_valid`, then `resp_valid` ← 0.
  - Otherwise all state holds.
  - `rr_ptr` never moves without an accept.
- **Result register states.** Two states: EMPTY (`resp_valid`=0) and FULL (`resp_valid`=1).
  - EMPTY → FULL on accept.
  - FULL → FULL when a new accept happens in the same cycle as `resp_ready`; back-to-back throughput is 1 per cycle.
  - FULL → EMPTY on `resp_ready` with no accept.
  - FULL with `resp_ready`=0 holds `resp_class` and `resp_id` stable, and `req_ready` is all zero.
- A requester that drops `req_valid` before it is accepted is simply skipped; no state is kept per requester.

## Timing

- **Reset.** `rst` asserted asynchronously clears, immediately:
  - `resp_valid`=0, `resp_id`=0, `resp_class`=0, `rr_ptr`=0, `issue_cnt`=0.
  - `req_ready` is forced to 0 while `rst`=1.
- **Reset mid-operation.** A result held in the register is discarded. No accept occurs in a cycle where `rst` is high at the clock edge.
- **Latency.** An accept at edge N gives `resp_valid`=1 with the result after edge N, i.e. visible in cycle N+1.
- **Wrap-around.** `rr_ptr` wraps from `NREQ-1` to 0. `issue_cnt` wraps from FFFF to 0000.
- **Valid/ready rule.** `resp_valid`, once high, stays high with stable data until `resp_ready` is sampled high.

## Test plan

- **Reset and single request.** Reset, then `req_valid`=0001 with operand 0x3F800000. Required: `req_ready`=0001 in the same cycle; next cycle `resp_valid`=1, `resp_id`=0, `resp_class`=0x008; `issue_cnt`=1.
- **Class coverage on requester 2.** Drive 0xFF800000, 0x80000000, 0x00000001, 0x7F800001, 0x7FC00000, 0x7F800000 back-to-back with `resp_ready`=1. Required results: 0x200, 0x040, 0x010, 0x002, 0x001, 0x004, one per cycle.
- **Fairness.** Hold `req_valid`=1111 with `resp_ready`=1. Required grant sequence 0, 1, 2, 3, 0, … Then with `req_valid`=1010 starting from `rr_ptr`=2, required grants 3, 1, 3.
- **Backpressure.** Result FULL and `resp_ready`=0 for 5 cycles with all requesters valid. Required: `req_ready`=0000, `resp_class` and `resp_id` unchanged, `rr_ptr` unchanged. On `resp_ready`=1, an accept happens in that same cycle.
- **Async reset mid-stream.** Assert `rst` between edges while FULL. Required: `resp_valid`, `rr_ptr` and `issue_cnt` go to 0 before the next edge. After release, a first request from requester 3 is granted and `resp_id`=3.
- **Counter wrap.** Preload the count by issuing 65535 requests, then issue one more. Required: `issue_cnt` goes 0xFFFF → 0x0000.
